vita49_unpack: RTL and testbench

- Receive-side counterpart of the team's VITA-49 packer. Consumes IF Data packets (with stream ID) on an AXI4-Stream slave, parses and strips the header, stream ID, timestamps and optional trailer, and forwards only payload words on an AXI4-Stream master.
- Sits between the link/DMA ingress and the DAC/sample sink.
- Exposes the last packet's timestamp, trailer, packet count and error counters to the processor.

---
 rtl/vita49_unpack.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_vita49_unpack.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_unpack.sv
// VITA-49 IF Data (with stream ID) receiver: strips header, SID, timestamps and trailer, forwards payload.
// Optional packet-count sequence checking is compiled in with `define VITA49_UNPACK_SEQ_CHECK_EN.
module vita49_unpack #(
  parameter int MAX_PKT_WORDS = 65535,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESETN,
  input  logic [31:0]          S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  input  logic                 S_AXIS_TLAST,
  output logic                 S_AXIS_TREADY,
  output logic [31:0]          M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY,
  input  logic [31:0]          ctrl,
  input  logic [31:0]          streamID,
  output logic [31:0]          status,
  output logic [31:0]          timestamp_sec,
  output logic [63:0]          timestamp_fsec,
  output logic [31:0]          trailer,
  output logic [31:0]          pkt_ok_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [3:0] {HDR, SID, TSI, TSF0, TSF1, PAYLOAD, TRAIL, DROP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl_p0;
  logic        en, srst, pass_req, sid_chk;
  logic        ctrl_unused;

  logic [15:0] rem;
  logic [3:0]  hdr_pcnt;
  logic        hdr_tsi, hdr_tsf, hdr_t;
  logic [31:0] tsi_sh, tsf0_sh, tsf1_sh;
  logic [3:0]  pkt_cnt_last;
  logic [7:0]  err_flags, err_set;
  logic        pass_act, bnd, at_bnd, pass_eff;
  logic        s_ready, m_valid, m_last, s_xfr;
  logic        commit, cap_hdr, cap_tsi, cap_tsf0, cap_tsf1, cap_trl, pay_xfr;
  logic        last_pay;

  logic [15:0]        f_size;
  logic [3:0]         f_pcnt, f_type;
  logic               f_tsi, f_tsf, f_t, f_c, hdr_bad;
  logic signed [16:0] n_pay;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign en          = ctrl_p0[0];
  assign srst        = ctrl_p0[1];
  assign pass_req    = ctrl_p0[2];
  assign sid_chk     = ctrl_p0[3];
  assign ctrl_unused = ^ctrl[31:4];

  assign f_size = S_AXIS_TDATA[15:0];
  assign f_pcnt = S_AXIS_TDATA[19:16];
  assign f_tsf  = (S_AXIS_TDATA[21:20] != 2'b00);
  assign f_tsi  = (S_AXIS_TDATA[23:22] != 2'b00);
  assign f_t    = S_AXIS_TDATA[26];
  assign f_c    = S_AXIS_TDATA[27];
  assign f_type = S_AXIS_TDATA[31:28];

  assign n_pay = $signed({1'b0, f_size}) - 17'sd2 - $signed({16'd0, f_tsi})
               - $signed({15'd0, f_tsf, 1'b0}) - $signed({16'd0, f_t});
  assign hdr_bad = (f_type != 4'b0001) || f_c || (32'(f_size) > MAX_PKT_WORDS)
                || (n_pay < 17'sd1) || S_AXIS_TLAST;

`ifdef VITA49_UNPACK_SEQ_CHECK_EN
  logic [3:0] seq_exp;
  logic       seq_seeded, seq_bad;
  assign seq_bad = seq_seeded && (f_pcnt != seq_exp);
`endif

  // Passthrough may only switch on a packet boundary, in either direction.
  assign at_bnd   = pass_act ? bnd : (state == HDR);
  assign pass_eff = at_bnd ? pass_req : pass_act;
  assign last_pay = (rem == 16'd1);

  always_comb begin
    state_nxt = state;
    err_set   = '0;
    commit    = 1'b0;
    cap_hdr   = 1'b0;
    cap_tsi   = 1'b0;
    cap_tsf0  = 1'b0;
    cap_tsf1  = 1'b0;
    cap_trl   = 1'b0;
    pay_xfr   = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    if (pass_eff) begin
      s_ready = M_AXIS_TREADY;
      m_valid = S_AXIS_TVALID;
      m_last  = S_AXIS_TLAST;
    end else begin
      unique case (state)
        HDR:     s_ready = en;
        PAYLOAD: begin
          s_ready = M_AXIS_TREADY;
          m_valid = S_AXIS_TVALID;
          m_last  = last_pay | S_AXIS_TLAST;
        end
        default: s_ready = 1'b1;
      endcase
    end
    if (srst) begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
    s_xfr = S_AXIS_TVALID & s_ready;

    // Entering DROP on a word that already carries TLAST would swallow the next packet, so go to HDR.
    if (s_xfr && !pass_eff) begin
      unique case (state)
        HDR: begin
          if (hdr_bad) begin
            err_set[0] = 1'b1;
            state_nxt  = S_AXIS_TLAST ? HDR : DROP;
          end else begin
            cap_hdr   = 1'b1;
            state_nxt = SID;
`ifdef VITA49_UNPACK_SEQ_CHECK_EN
            err_set[4] = seq_bad;
`endif
          end
        end
        SID: begin
          if (sid_chk && (S_AXIS_TDATA != streamID)) begin
            err_set[1] = 1'b1;
            state_nxt  = S_AXIS_TLAST ? HDR : DROP;
          end else if (S_AXIS_TLAST) begin
            err_set[3] = 1'b1;
            state_nxt  = HDR;
          end else begin
            state_nxt = hdr_tsi ? TSI : (hdr_tsf ? TSF0 : PAYLOAD);
          end
        end
        TSI: begin
          if (S_AXIS_TLAST) begin
            err_set[3] = 1'b1;
            state_nxt  = HDR;
          end else begin
            cap_tsi   = 1'b1;
            state_nxt = hdr_tsf ? TSF0 : PAYLOAD;
          end
        end
        TSF0: begin
          if (S_AXIS_TLAST) begin
            err_set[3] = 1'b1;
            state_nxt  = HDR;
          end else begin
            cap_tsf0  = 1'b1;
            state_nxt = TSF1;
          end
        end
        TSF1: begin
          if (S_AXIS_TLAST) begin
            err_set[3] = 1'b1;
            state_nxt  = HDR;
          end else begin
            cap_tsf1  = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_xfr = 1'b1;
          if (last_pay && !hdr_t) begin
            if (S_AXIS_TLAST) begin
              commit    = 1'b1;
              state_nxt = HDR;
            end else begin
              err_set[2] = 1'b1;
              state_nxt  = DROP;
            end
          end else if (S_AXIS_TLAST) begin
            err_set[3] = 1'b1;
            state_nxt  = HDR;
          end else if (last_pay) begin
            state_nxt = TRAIL;
          end
        end
        TRAIL: begin
          if (S_AXIS_TLAST) begin
            commit    = 1'b1;
            cap_trl   = 1'b1;
            state_nxt = HDR;
          end else begin
            err_set[2] = 1'b1;
            state_nxt  = DROP;
          end
        end
        DROP:    if (S_AXIS_TLAST) state_nxt = HDR;
        default: state_nxt = HDR;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_last;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign status        = {err_flags, pkt_cnt_last, 16'h0000, state};

  // ctrl register stage
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) ctrl_p0 <= '0;
    else               ctrl_p0 <= ctrl[3:0];
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)  state <= HDR;
    else if (srst)      state <= HDR;
    else                state <= state_nxt;
  end

  // Per-packet header fields and shadows; shadows clear at each header so
  // packets without a TSI/TSF report zero rather than a stale value.
  always_ff @(posedge AXIS_ACLK) begin
    if (cap_hdr) begin
      rem      <= n_pay[15:0];
      hdr_pcnt <= f_pcnt;
      hdr_tsi  <= f_tsi;
      hdr_tsf  <= f_tsf;
      hdr_t    <= f_t;
      tsi_sh   <= '0;
      tsf0_sh  <= '0;
      tsf1_sh  <= '0;
    end
    if (pay_xfr)  rem     <= rem - 16'd1;
    if (cap_tsi)  tsi_sh  <= S_AXIS_TDATA;
    if (cap_tsf0) tsf0_sh <= S_AXIS_TDATA;
    if (cap_tsf1) tsf1_sh <= S_AXIS_TDATA;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN || srst) begin
      timestamp_sec  <= '0;
      timestamp_fsec <= '0;
      trailer        <= '0;
      pkt_ok_cnt     <= '0;
      pkt_cnt_last   <= '0;
      err_flags      <= '0;
      err_cnt        <= '0;
      pass_act       <= 1'b0;
      bnd            <= 1'b1;
    end else begin
      pass_act <= pass_eff;
      if (s_xfr) bnd <= S_AXIS_TLAST;
      if (commit) begin
        timestamp_sec  <= tsi_sh;
        timestamp_fsec <= {tsf0_sh, tsf1_sh};
        pkt_cnt_last   <= hdr_pcnt;
        pkt_ok_cnt     <= pkt_ok_cnt + 32'd1;
      end
      if (cap_trl) trailer <= S_AXIS_TDATA;
      err_flags <= err_flags | err_set;
      if (|err_set) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef VITA49_UNPACK_SEQ_CHECK_EN
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN || srst) begin
      seq_exp    <= '0;
      seq_seeded <= 1'b0;
    end else if (cap_hdr) begin
      seq_exp    <= f_pcnt + 4'd1;
      seq_seeded <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vita49_unpack.sv
// Scoreboard bench for vita49_unpack: a packet-level reference model queues expected payload words,
// a monitor pops and compares them at every output transfer.
`timescale 1ns/1ps
module tb_vita49_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [31:0] ctrl = '0;
  logic [31:0] sid_val = 32'h0000_5678;
  logic [31:0] status, timestamp_sec, trailer, pkt_ok_cnt;
  logic [63:0] timestamp_fsec;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  vita49_unpack dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .ctrl(ctrl), .streamID(sid_val), .status(status),
    .timestamp_sec(timestamp_sec), .timestamp_fsec(timestamp_fsec), .trailer(trailer),
    .pkt_ok_cnt(pkt_ok_cnt), .err_cnt(err_cnt)
  );

  int          compared = 0, mismatched = 0;
  logic [32:0] exp_q[$];
  logic [32:0] pkt[$];
  logic [32:0] mon_e;
  int          rdy_mode = 0;
  bit          chk_follow = 1'b0;
  bit          sid_chk_on = 1'b0;
  logic [3:0]  tb_pc = 4'd0;

  logic [31:0] m_ok, m_tsi, m_trl;
  logic [63:0] m_tsf;
  logic [7:0]  m_flags;
  logic [3:0]  m_pcl, m_seq_exp;
  logic [15:0] m_err;
  bit          m_seeded;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ok = '0; m_tsi = '0; m_trl = '0; m_tsf = '0; m_flags = '0; m_pcl = '0;
    m_err = '0; m_seq_exp = '0; m_seeded = 1'b0;
  endtask

  function automatic logic [31:0] mk_hdr(input logic [3:0] typ, input bit c, input bit t,
                                          input logic [1:0] tsi, input logic [1:0] tsf,
                                          input logic [3:0] pc, input logic [15:0] size);
    return {typ, c, t, 2'b00, tsi, tsf, pc, size};
  endfunction

  task automatic build_pkt(input logic [31:0] hdr, input logic [31:0] sid, input int len);
    logic [31:0] w;
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      w = (i == 0) ? hdr : (i == 1) ? sid : $urandom();
      pkt.push_back({(i == len - 1), w});
    end
  endtask

  // Packet-level reference: where the packet ends relative to its declared size decides the outcome.
  task automatic model_pkt();
    logic [31:0] h;
    int L, size, tsi, tsf, t, nh, np, xl, lastp, ev;
    h = pkt[0][31:0];
    L = pkt.size() - 1;
    size = int'(h[15:0]);
    tsi = (h[23:22] != 2'b00) ? 1 : 0;
    tsf = (h[21:20] != 2'b00) ? 1 : 0;
    t = h[26] ? 1 : 0;
    nh = 2 + tsi + 2 * tsf;
    np = size - nh - t;
    xl = nh + np + t - 1;
    lastp = nh + np - 1;
    ev = 0;
    if (h[31:28] != 4'd1 || h[27] || np < 1 || L == 0) begin
      m_flags[0] = 1'b1; ev = 1;
    end else begin
`ifdef VITA49_UNPACK_SEQ_CHECK_EN
      if (m_seeded && h[19:16] != m_seq_exp) begin m_flags[4] = 1'b1; ev++; end
      m_seq_exp = h[19:16] + 4'd1;
      m_seeded = 1'b1;
`endif
      if (sid_chk_on && pkt[1][31:0] != sid_val) begin
        m_flags[1] = 1'b1; ev++;
      end else if (L < xl) begin
        m_flags[3] = 1'b1; ev++;
        for (int i = nh; i <= L && i <= lastp; i++)
          exp_q.push_back({(i == L || i == lastp), pkt[i][31:0]});
      end else begin
        for (int i = nh; i <= lastp; i++) exp_q.push_back({(i == lastp), pkt[i][31:0]});
        if (L == xl) begin
          m_ok = m_ok + 32'd1;
          m_pcl = h[19:16];
          m_tsi = (tsi != 0) ? pkt[2][31:0] : 32'd0;
          m_tsf = (tsf != 0) ? {pkt[2 + tsi][31:0], pkt[3 + tsi][31:0]} : 64'd0;
          if (t != 0) m_trl = pkt[L][31:0];
        end else begin
          m_flags[2] = 1'b1; ev++;
        end
      end
    end
    repeat (ev) if (m_err != 16'hFFFF) m_err++;
  endtask

  task automatic drive_pkt();
    int  waited;
    bit  got;
    for (int i = 0; i < pkt.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1; s_tdata = pkt[i][31:0]; s_tlast = pkt[i][32];
      waited = 0;
      do begin
        @(negedge clk); got = s_tready;
        @(posedge clk); #1;
        waited++;
      end while (!got && waited < 200);
      if (!got) begin
        compared++; mismatched++;
        $display("FAIL input_handshake: word %0d not accepted within 200 cycles, expected acceptance", i);
        break;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic check_regs();
    check("pkt_ok_cnt", 64'(pkt_ok_cnt), 64'(m_ok));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    check("err_flags", 64'(status[31:24]), 64'(m_flags));
    check("pkt_cnt_last", 64'(status[23:20]), 64'(m_pcl));
    check("timestamp_sec", 64'(timestamp_sec), 64'(m_tsi));
    check("timestamp_fsec", timestamp_fsec, m_tsf);
    check("trailer", 64'(trailer), 64'(m_trl));
  endtask

  task automatic run_pkt();
    model_pkt();
    drive_pkt();
    check_regs();
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    ctrl = v;
    repeat (2) @(posedge clk);
    #1;
    sid_chk_on = v[3];
  endtask

  task automatic gen_random();
    logic [1:0] tsi, tsf;
    logic [3:0] typ, pc;
    bit t, c;
    int nh, np, size, len, mode;
    logic [31:0] sid;
    tsi = 2'($urandom_range(0, 3));
    tsf = 2'($urandom_range(0, 3));
    t = ($urandom_range(0, 1) == 1);
    c = ($urandom_range(0, 11) == 0);
    typ = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
    pc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : tb_pc;
    tb_pc = pc + 4'd1;
    nh = 2 + ((tsi != 2'b00) ? 1 : 0) + ((tsf != 2'b00) ? 2 : 0);
    np = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 6));
    size = nh + np + (t ? 1 : 0);
    mode = $urandom_range(0, 9);
    len = size;
    if (mode == 8) len = $urandom_range(1, size - 1);
    else if (mode == 9) len = size + int'($urandom_range(1, 2));
    sid = ($urandom_range(0, 4) == 0) ? $urandom() : sid_val;
    build_pkt(mk_hdr(typ, c, t, tsi, tsf, pc, 16'(size)), sid, len);
    run_pkt();
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_follow && m_tvalid) check("s_ready_follows_m_ready", 64'(s_tready), 64'(m_tready));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL out_word: got 0x%0h, expected no output", {m_tlast, m_tdata});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_word", 64'({m_tlast, m_tdata}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready_disabled", 64'(s_tready), 64'd0);
    check("rst_m_tvalid_after", 64'(m_tvalid), 64'd0);
    check("rst_status_hi", 64'(status[31:4]), 64'd0);
    check_regs();

    set_ctrl(32'h1);
    // TSI+TSF, no trailer, size 9: four payload words
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b01, 2'b01, tb_pc, 16'd9), sid_val, 9);
    tb_pc++;
    run_pkt();
    // with trailer: three payload words
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b1, 2'b01, 2'b01, tb_pc, 16'd9), sid_val, 9);
    pkt[8] = {1'b1, 32'hA5A5_0000};
    tb_pc++;
    run_pkt();
    check("trailer_directed", 64'(trailer), 64'h0000_0000_A5A5_0000);

    // stream-ID mismatch then a good packet
    set_ctrl(32'h9);
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b01, 2'b01, tb_pc, 16'd9), 32'h0000_1234, 9);
    tb_pc++;
    run_pkt();
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b01, 2'b01, tb_pc, 16'd9), sid_val, 9);
    tb_pc++;
    run_pkt();

    // early TLAST on the second payload word
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b01, 2'b01, tb_pc, 16'd9), sid_val, 7);
    tb_pc++;
    run_pkt();

    // output ready toggling during a long payload
    rdy_mode = 1; chk_follow = 1'b1;
    build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b01, 2'b00, tb_pc, 16'd14), sid_val, 14);
    tb_pc++;
    run_pkt();
    chk_follow = 1'b0; rdy_mode = 0;

    // packet-count sequence with a gap on the third packet
    for (int k = 0; k < 3; k++) begin
      build_pkt(mk_hdr(4'd1, 1'b0, 1'b0, 2'b00, 2'b00, tb_pc + 4'(k == 2 ? 3 : k), 16'd4), sid_val, 4);
      run_pkt();
    end
    tb_pc = tb_pc + 4'd4;

    // soft reset
    @(posedge clk); #1;
    ctrl = ctrl | 32'h2;
    @(posedge clk); #1;
    ctrl = ctrl & ~32'h2;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_regs();

    // passthrough
    set_ctrl(32'h5);
    build_pkt($urandom(), $urandom(), 4);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    drive_pkt();
    set_ctrl(32'h1);
    check_regs();

    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) set_ctrl(($urandom_range(0, 1) == 1) ? 32'h9 : 32'h1);
      gen_random();
    end
    rdy_mode = 0;

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
